fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side stage placed directly downstream of the FIFO controller and its RAM. It issues `fifo_read_req` whenever the FIFO is non-empty and local space is reserved, captures the RAM read data after a fixed latency, and presents it as a first-word-fall-through valid/ready stream. An internal skid buffer absorbs in-flight reads, so downstream back-pressure never loses data and the stage sustains one word per cycle.

## Interface
- `WIDTH`, 8, data width; matches the FIFO controller's `WIDTH`.
- `READ_LATENCY`, 2, cycles from `fifo_read_req` high to valid data on `ram_read_data`; range 1–4.
- `BUF_DEPTH_LOG`, 2, log2 of the skid buffer depth. Full throughput requires 2**BUF_DEPTH_LOG ≥ READ_LATENCY+1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `fifo_empty`  in  1  empty flag from the FIFO controller.
- `fifo_read_req`  out  1  read request to the FIFO controller; combinational.
- `ram_read_data`  in  WIDTH  RAM read-port data.
- `flush`  in  1  synchronous discard of buffered and in-flight words.
- `dout_valid`  out  1  head word available; registered.
- `dout_data`  out  WIDTH  head word; registered.
- `dout_ready`  in  1  consumer accepts the head word this cycle.
- `word_count`  out  16  accepted-word counter; present only with the macro below.

## Operation
- **Skid buffer:** 2**BUF_DEPTH_LOG entries, circular, with write pointer, read pointer and occupancy counter. Pointers wrap modulo the depth.
- **In-flight tracker:** a READ_LATENCY-bit shift register. Bit 0 is loaded with `fifo_read_req`. When the top bit is 1, `ram_read_data` is pushed into the buffer at the end of that cycle.
- **Issue rule:** `fifo_read_req = rst_n & !flush & !fifo_empty & (occupancy + inflight_ones < 2**BUF_DEPTH_LOG)`.
  - The occupancy term uses the registered value only; a same-cycle pop does not free credit.
  - This is conservative, and it makes buffer overflow impossible.
- **Pop:** happens when `dout_valid & dout_ready`. The head advances, and the next entry (if any) appears on `dout_data` at the following edge.
- **Simultaneous push and pop:** both complete; occupancy is unchanged. This is legal with the buffer full.
- **Flush:** at the next edge, occupancy = 0, pointers = 0, the in-flight tracker is cleared and `dout_valid` = 0.
  - RAM data arriving in that cycle is dropped.
  - Flush wins over a simultaneous push or pop.
  - The pop is not counted.
- **Reset values:** `dout_valid` 0, `dout_data` 0, all pointers, counters and tracker 0. `fifo_read_req` is 0 while `rst_n` is low.
- **Reset mid-stream:** all buffered and in-flight words are lost. The FIFO controller is reset by the same `rst_n`.

## Timing
- **Read latency:** `fifo_read_req` high in cycle t puts data on `ram_read_data` in cycle t+READ_LATENCY. `dout_valid` rises in cycle t+READ_LATENCY+1. With defaults: 3 cycles from request to output, first word.
- **Throughput:** with `dout_ready` held high and the FIFO non-empty, one word per cycle after the initial latency.
- **Stall:** with `dout_ready` low, issue stops once occupancy plus in-flight reaches the depth. At most 2**BUF_DEPTH_LOG words are held.
- **Resume:** `dout_ready` rising gives one pop per cycle immediately. Reissue starts the cycle after the first pop reduces occupancy.
- **Empty:** `fifo_read_req` is low while `fifo_empty` is high. Issue resumes in the first cycle `fifo_empty` is low.
- **Flush:** `fifo_read_req` is low in the flush cycle. Issue can resume in the cycle after.

## Configuration
- **Macro `FIFO_STREAM_READER_COUNT_EN`.**
  - Defined: the 16-bit `word_count` port is present. It resets to 0, increments on every pop that is not coincident with `flush`, and wraps 0xFFFF→0x0000. It is not cleared by `flush`.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- **Single word:** FIFO loaded with 0xA5, `dout_ready`=1, defaults → `fifo_read_req` one cycle; `dout_valid` high 3 cycles later with 0xA5 for exactly 1 cycle.
- **Streaming:** 16 words 0x00–0x0F, `dout_ready`=1 → 0x00..0x0F in order on consecutive cycles; no gaps after the first.
- **Back-pressure:** 10 words, `dout_ready`=0 → issue stops with exactly 4 words held (depth 4); `dout_valid` stays high with 0x00. Raising `dout_ready` delivers all 10 in order, no loss or duplication.
- **Flush in flight:** flush asserted 1 cycle after a read request, with 2 words buffered → `dout_valid`=0 next cycle. The in-flight word never appears; subsequent words are delivered normally.
- **Reset mid-stream:** `rst_n` dropped with 3 words buffered → `dout_valid`, `dout_data` and `word_count` = 0 asynchronously; `fifo_read_req` = 0 while reset is low.
- **Counter wrap (macro defined):** `word_count` preset path via 65,537 accepted words → `word_count` = 1. A pop coincident with flush does not increment it.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - handshake bundle between FIFO/RAM, reader and consumer
//
// Purpose: groups the FIFO-controller read side and the downstream valid/ready
// stream of fifo_stream_reader into one interface.
// Signals:
//   fifo_empty     FIFO controller empty flag (into reader)
//   fifo_read_req  read request to FIFO controller (from reader, combinational)
//   ram_read_data  RAM read-port data (into reader)
//   dout_valid     head word available (from reader, registered)
//   dout_data      head word (from reader, registered)
//   dout_ready     consumer accepts head word (into reader)
// Modports: master = the reader stage, slave = its surroundings.

interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic             fifo_read_req;
  logic [WIDTH-1:0] ram_read_data;
  logic             dout_valid;
  logic [WIDTH-1:0] dout_data;
  logic             dout_ready;

  modport master (
    input  fifo_empty,
    input  ram_read_data,
    input  dout_ready,
    output fifo_read_req,
    output dout_valid,
    output dout_data
  );

  modport slave (
    output fifo_empty,
    output ram_read_data,
    output dout_ready,
    input  fifo_read_req,
    input  dout_valid,
    input  dout_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read stage with skid buffer and FWFT stream output
//
// Purpose: issues FIFO reads while space is reserved, captures RAM data after
// READ_LATENCY cycles into a circular skid buffer and presents the head as a
// registered first-word-fall-through valid/ready stream.
// Ports:
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         fifo_stream_reader_if.master (fifo_empty, fifo_read_req,
//               ram_read_data, dout_valid, dout_data, dout_ready)
//   flush       synchronous discard of buffered and in-flight words
//   word_count  16-bit accepted-word counter, only when the optional macro
//               FIFO_STREAM_READER_COUNT_EN is defined

module fifo_stream_reader #(
  parameter int WIDTH         = 8,
  parameter int READ_LATENCY  = 2,
  parameter int BUF_DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus,
  input  logic                 flush
`ifdef FIFO_STREAM_READER_COUNT_EN
  ,
  output logic [15:0]          word_count
`endif
);

  localparam int DEPTH = 1 << BUF_DEPTH_LOG;
  localparam int PW    = BUF_DEPTH_LOG;
  localparam int CW    = BUF_DEPTH_LOG + 1;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           rd_ptr_n;
  logic [CW-1:0]           occ;
  logic [CW-1:0]           occ_n;
  logic [READ_LATENCY-1:0] inflight;
  logic [7:0]              inflight_ones;
  logic [7:0]              credit_used;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    dout_valid_q;
  logic [WIDTH-1:0]        dout_data_q;
  logic [WIDTH-1:0]        dout_data_n;

  always_comb begin
    inflight_ones = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_ones = inflight_ones + 8'(inflight[i]);
    end
  end

  // Credit counts registered occupancy only: a same-cycle pop frees nothing,
  // which keeps the buffer from ever overflowing.
  assign credit_used = 8'(occ) + inflight_ones;
  assign issue = rst_n & ~flush & ~bus.fifo_empty & (credit_used < 8'(DEPTH));
  assign bus.fifo_read_req = issue;

  assign push = inflight[READ_LATENCY-1];
  assign pop  = dout_valid_q & bus.dout_ready;

  always_comb begin
    rd_ptr_n = pop ? rd_ptr + PW'(1) : rd_ptr;
    occ_n    = occ;
    if (push && !pop) begin
      occ_n = occ + CW'(1);
    end else if (!push && pop) begin
      occ_n = occ - CW'(1);
    end
    // When the incoming word is the only entry after this edge it bypasses
    // the memory so it can be the head immediately.
    if (push && (occ_n == CW'(1))) begin
      dout_data_n = bus.ram_read_data;
    end else begin
      dout_data_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= bus.ram_read_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      inflight     <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      inflight     <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr       <= rd_ptr_n;
      occ          <= occ_n;
      inflight     <= (inflight << 1) | READ_LATENCY'(issue);
      dout_valid_q <= (occ_n != '0);
      dout_data_q  <= dout_data_n;
    end
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_data  = dout_data_q;

`ifdef FIFO_STREAM_READER_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (pop && !flush) begin
      word_count <= word_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader

module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
`ifdef FIFO_STREAM_READER_COUNT_EN
  logic [15:0] word_count;
`endif

  fifo_stream_reader_if #(.WIDTH(8)) bus ();

  fifo_stream_reader #(
    .WIDTH(8),
    .READ_LATENCY(2),
    .BUF_DEPTH_LOG(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .flush(flush)
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO controller + RAM model: 2-cycle read latency, reset by the same rst_n.
  logic [7:0] fmem [0:255];
  int         fifo_wr = 0;
  int         fifo_rd = 0;
  logic [7:0] st0 = 8'h00;
  logic [7:0] st1 = 8'h00;

  assign bus.fifo_empty    = (fifo_wr == fifo_rd);
  assign bus.ram_read_data = st1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd <= fifo_wr;
      st0     <= 8'h00;
      st1     <= 8'h00;
    end else begin
      if (bus.fifo_read_req) begin
        st0     <= fmem[fifo_rd[7:0]];
        fifo_rd <= fifo_rd + 1;
      end else begin
        st0 <= 8'hEE;
      end
      st1 <= st0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rx_q [$];
  int         rx_cyc [$];

  always @(negedge clk) begin
    #1;
    if (rst_n && !flush && bus.dout_valid && bus.dout_ready) begin
      rx_q.push_back(bus.dout_data);
      rx_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    fmem[fifo_wr[7:0]] = d;
    fifo_wr = fifo_wr + 1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_cyc.delete();
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #2;
    check(tag, 32'(rx_q.size()), 32'(n));
  endtask

  int base;

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.dout_ready = 1'b0;

    // Reset state
    step(3);
    #1;
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_data", 32'(bus.dout_data), 32'd0);
    check("rst_req", 32'(bus.fifo_read_req), 32'd0);
`ifdef FIFO_STREAM_READER_COUNT_EN
    check("rst_count", 32'(word_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    // Single word: request, then valid 3 cycles later for exactly one cycle
    rx_clear();
    @(negedge clk);
    bus.dout_ready = 1'b1;
    push_word(8'hA5);
    #1;
    check("sw_req_on", 32'(bus.fifo_read_req), 32'd1);
    @(negedge clk); #1;
    check("sw_req_off", 32'(bus.fifo_read_req), 32'd0);
    check("sw_valid_t1", 32'(bus.dout_valid), 32'd0);
    @(negedge clk); #1;
    check("sw_valid_t2", 32'(bus.dout_valid), 32'd0);
    @(negedge clk); #1;
    check("sw_valid_t3", 32'(bus.dout_valid), 32'd1);
    check("sw_data_t3", 32'(bus.dout_data), 32'hA5);
    @(negedge clk); #1;
    check("sw_valid_t4", 32'(bus.dout_valid), 32'd0);
    step(2);

    // Streaming: 16 words on consecutive cycles
    rx_clear();
    @(negedge clk);
    for (int i = 0; i < 16; i++) push_word(8'(i));
    wait_rx("st_count", 16, 100);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      check($sformatf("st_data%0d", i), 32'(rx_q[i]), 32'(i));
    end
    if (rx_cyc.size() == 16) check("st_no_gaps", 32'(rx_cyc[15] - rx_cyc[0]), 32'd15);
    step(4);
    check("st_no_dup", 32'(rx_q.size()), 32'd16);

    // Back-pressure: exactly 4 words issued, head holds 0x00
    rx_clear();
    @(negedge clk);
    bus.dout_ready = 1'b0;
    base = fifo_rd;
    for (int i = 0; i < 10; i++) push_word(8'(i));
    step(10);
    #1;
    check("bp_issued", 32'(fifo_rd - base), 32'd4);
    check("bp_req_off", 32'(bus.fifo_read_req), 32'd0);
    check("bp_valid", 32'(bus.dout_valid), 32'd1);
    check("bp_head", 32'(bus.dout_data), 32'h00);
    @(negedge clk);
    bus.dout_ready = 1'b1;
    wait_rx("bp_count", 10, 100);
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      check($sformatf("bp_data%0d", i), 32'(rx_q[i]), 32'(i));
    end
    step(4);
    check("bp_no_dup", 32'(rx_q.size()), 32'd10);

    // Flush one cycle after a request, with 2 words buffered
    rx_clear();
    @(negedge clk);
    bus.dout_ready = 1'b0;
    push_word(8'h40);
    push_word(8'h41);
    step(6);
    push_word(8'h50);
    push_word(8'h51);
    push_word(8'h52);
    #1;
    check("fl_req_before", 32'(bus.fifo_read_req), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_req_in_flush", 32'(bus.fifo_read_req), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_valid_after", 32'(bus.dout_valid), 32'd0);
    bus.dout_ready = 1'b1;
    wait_rx("fl_count", 2, 50);
    if (rx_q.size() >= 2) begin
      check("fl_data0", 32'(rx_q[0]), 32'h51);
      check("fl_data1", 32'(rx_q[1]), 32'h52);
    end
    step(4);
    check("fl_no_extra", 32'(rx_q.size()), 32'd2);

    // Reset mid-stream with 3 words buffered
    rx_clear();
    @(negedge clk);
    bus.dout_ready = 1'b0;
    push_word(8'h31);
    push_word(8'h32);
    push_word(8'h33);
    step(6);
    #1;
    check("mr_pre_data", 32'(bus.dout_data), 32'h31);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(bus.dout_valid), 32'd0);
    check("mr_data", 32'(bus.dout_data), 32'd0);
`ifdef FIFO_STREAM_READER_COUNT_EN
    check("mr_count", 32'(word_count), 32'd0);
`endif
    push_word(8'h77);
    #1;
    check("mr_req", 32'(bus.fifo_read_req), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    rx_clear();
    bus.dout_ready = 1'b1;
    push_word(8'h60);
    wait_rx("mr_after_count", 1, 20);
    if (rx_q.size() >= 1) check("mr_after_data", 32'(rx_q[0]), 32'h60);

`ifdef FIFO_STREAM_READER_COUNT_EN
    // Counter wrap over 65,537 accepted words
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("wc_reset", 32'(word_count), 32'd0);
    rx_clear();
    begin
      int fed;
      int k;
      fed = 0;
      k = 0;
      while (rx_q.size() < 65537 && k < 80000) begin
        @(negedge clk);
        if (fed < 65537 && (fifo_wr - fifo_rd) < 16) begin
          push_word(8'(fed));
          fed++;
        end
        k++;
      end
    end
    step(3);
    #1;
    check("wc_rx", 32'(rx_q.size()), 32'd65537);
    check("wc_wrap", 32'(word_count), 32'd1);

    // Pop coincident with flush is not counted
    @(negedge clk);
    bus.dout_ready = 1'b0;
    push_word(8'h99);
    step(5);
    #1;
    check("wc_fl_valid_pre", 32'(bus.dout_valid), 32'd1);
    @(negedge clk);
    flush          = 1'b1;
    bus.dout_ready = 1'b1;
    @(negedge clk);
    flush          = 1'b0;
    bus.dout_ready = 1'b0;
    #1;
    check("wc_fl_count", 32'(word_count), 32'd1);
    check("wc_fl_valid", 32'(bus.dout_valid), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
